data_mem_bus: RTL

- Parametrised successor of the single-cycle word data memory.
- Byte-addressed, with MIPS load/store sizes: byte, half and word. Loads support sign or zero extension.
- Misaligned accesses are detected and reported as errors.
- Requests and responses use a valid/ready handshake. A configurable access latency lets the pipeline model a slow memory and stall on it.
- Sits between the MEM stage and the storage array.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/data_mem_bus.sv | 109 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the handshaked byte-addressed data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extract/extend, store merge and misalignment detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = old_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        err = (size == 2'd3)
            || (size == SZ_HALF && addr_lo[0])
            || (size == SZ_WORD && addr_lo != 2'd0);

        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            default: load_data = old_word;
        endcase

        // Untouched lanes keep their prior contents.
        store_word = old_word;
        case (size)
            SZ_BYTE: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            SZ_WORD: store_word = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_bus.sv
// Byte-addressed data memory with valid/ready request/response and configurable access latency.
module data_mem_bus
    import dmem_pkg::*;
#(
    parameter int unsigned  DEPTH   = 256,
    parameter int unsigned  LATENCY = 1,
    localparam int unsigned ADDR_W  = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [31:0]        wdata_q;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        old_word;
    logic [31:0]        load_data;
    logic [31:0]        store_word;
    logic               align_err;
    logic               mem_we;

    assign req_ready = (state_q == IDLE);
    assign old_word  = mem[addr_q[ADDR_W-1:2]];

    dmem_lane_align u_align (
        .old_word   (old_word),
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .is_signed  (signed_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .err        (align_err)
    );

    // An async reset drops state_q to IDLE at once, so an aborted store never commits.
    assign mem_we = clk_enable && (state_q == BUSY) && (cnt_q == '0) && write_q && !align_err;

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[ADDR_W-1:2]] <= store_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            size_q    <= SZ_BYTE;
            signed_q  <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (clk_enable) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata;
                        cnt_q    <= CNT_W'(LATENCY - 1);
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (align_err || write_q) ? 32'h0 : load_data;
                        rsp_err   <= align_err;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
